// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches one instruction at a time over a req/gnt/rvalid handshake,
// holds it for decode and selects the next PC from jump/branch on consumption.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  jump,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic        addr_err
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;
    state_t state;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign br_off    = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    // jr beats j/jal, which beat a taken branch
    always_comb next_pc = jump == 2'b01 ? {jr_target[31:2], 2'b00} :
                          jump[1]       ? {pc_plus4[31:28], instruction[25:0], 2'b00} :
                          branch_taken  ? pc_plus4 + br_off : pc_plus4;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_REQ;
            imem_req    <= 1'b1;
            pc          <= RESET_PC;
            instruction <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                S_REQ: if (imem_gnt) begin
                    state    <= S_WAIT;
                    imem_req <= 1'b0;
                end
                S_WAIT: if (imem_rvalid) begin
                    instruction <= imem_rdata;
                    instr_valid <= 1'b1;
                    state       <= S_VALID;
                end
                S_VALID: if (instr_ready) begin
                    pc          <= next_pc;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b1;
                    addr_err    <= jump == 2'b01 && |jr_target[1:0];
                    state       <= S_REQ;
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic, checked every cycle against
// a transaction-level model of the fetch unit.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  jump = 2'b00;
    logic        branch_taken = 1'b0;
    logic [31:0] jr_target = '0;
    logic        addr_err;

    int checks = 0;
    int failures = 0;

    // model: pending = request granted, response not yet seen; holding = word waiting for decode
    logic [31:0] m_pc = '0, m_instr = '0;
    logic        m_holding = 1'b0, m_pending = 1'b0, m_err = 1'b0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .pc_plus4(pc_plus4), .jump(jump), .branch_taken(branch_taken),
        .jr_target(jr_target), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input logic [1:0] j, input logic br, input logic [31:0] jt);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j == 2'd1) return jt & ~32'd3;
        if (j >= 2'd2) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        if (br) return p4 + 32'($signed(ins[15:0])) * 32'd4;
        return p4;
    endfunction

    task automatic compare();
        chk("imem_req", {31'd0, imem_req}, {31'd0, !m_pending && !m_holding});
        if (!m_pending && !m_holding) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        chk("instruction", instruction, m_instr);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    endtask

    // called just after a falling edge: drive inputs, advance the model, clock once, compare
    task automatic step(input logic rn, input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic [1:0] j, input logic br, input logic [31:0] jt);
        reset_n = rn; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        instr_ready = rdy; jump = j; branch_taken = br; jr_target = jt;
        if (!rn) begin
            m_pc = 32'h0; m_instr = '0; m_holding = 1'b0; m_pending = 1'b0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_holding) begin
                if (rdy) begin
                    m_err = j == 2'd1 && jt[1:0] != 2'd0;
                    m_pc = model_next(m_pc, m_instr, j, br, jt);
                    m_holding = 1'b0;
                end
            end else if (m_pending) begin
                if (rv) begin m_instr = rd; m_holding = 1'b1; m_pending = 1'b0; end
            end else if (g) m_pending = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic fetch(input logic [31:0] word);
        step(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step(1, 0, 1, word, 0, 0, 0, 0);
    endtask

    task automatic consume(input logic [1:0] j, input logic br, input logic [31:0] jt);
        step(1, 0, 0, 0, 1, j, br, jt);
    endtask

    initial begin
        logic g, rv, rdy, br, rn;
        logic [1:0] j;
        logic [31:0] jt;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h1111_1111, 1, 0, 0, 0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_req", {31'd0, imem_req}, 32'd1);
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_instr", instruction, 32'h0);
        // sequential fetch with immediate grant and one-cycle response
        step(1, 1, 0, 0, 1, 0, 0, 0);
        chk("lat_no_valid_yet", {31'd0, instr_valid}, 32'd0);
        step(1, 0, 1, 32'h2008_0005, 0, 0, 0, 0);
        chk("seq_word0", instruction, 32'h2008_0005);
        chk("seq_valid0", {31'd0, instr_valid}, 32'd1);
        consume(0, 0, 0);
        chk("seq_addr4", imem_addr, 32'h4);
        fetch(32'h0000_0000);
        consume(0, 0, 0);
        chk("seq_addr8", imem_addr, 32'h8);
        // stall in VALID with stray responses
        fetch(32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) step(1, i[0], !i[0], 32'h5555_0000 + i, 0, 0, 0, 0);
        chk("stall_instr", instruction, 32'hCAFE_F00D);
        chk("stall_pc", pc, 32'h8);
        // j/jal
        consume(2'd1, 0, 32'h0040_0010);
        fetch(32'h0C00_0100);
        chk("jal_pc", pc, 32'h0040_0010);
        chk("jal_pc_plus4", pc_plus4, 32'h0040_0014);
        consume(2'd3, 1, 0);
        chk("jal_target", imem_addr, 32'h0000_0400);
        // jr misaligned
        fetch(32'h0000_0008);
        consume(2'd1, 0, 32'h0000_1236);
        chk("jr_target", imem_addr, 32'h0000_1234);
        chk("jr_err_on", {31'd0, addr_err}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("jr_err_off", {31'd0, addr_err}, 32'd0);
        // branch taken, not taken, jump beating branch
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h1000_FFFE, 0, 0, 0, 0);
        consume(2'd1, 0, 32'h0000_0100);
        fetch(32'h1000_FFFE);
        consume(0, 1, 0);
        chk("br_taken", imem_addr, 32'h0000_00FC);
        fetch(0);
        consume(2'd1, 0, 32'h0000_0100);
        fetch(32'h1000_FFFE);
        consume(0, 0, 0);
        chk("br_not_taken", imem_addr, 32'h0000_0104);
        fetch(0);
        consume(2'd1, 0, 32'h0000_0100);
        fetch(32'h1000_FFFE);
        consume(2'd2, 1, 0);
        chk("jump_over_branch", imem_addr, 32'h0003_FFF8);
        // pc_plus4 wrap
        fetch(0);
        consume(2'd1, 0, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        fetch(32'h0000_0000);
        consume(0, 0, 0);
        chk("wrap_next", imem_addr, 32'h0);
        // reset while waiting, response arrives right after reset
        consume(2'd1, 0, 32'h0000_0800);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h7777_7777, 0, 0, 0, 0);
        chk("rst_mid_req", {31'd0, imem_req}, 32'd1);
        chk("rst_mid_addr", imem_addr, 32'h0);
        chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rn  = ($urandom % 100) != 0;
            g   = ($urandom % 3) == 0;
            rv  = m_pending ? ($urandom % 5) < 2 : ($urandom % 5) == 0;
            rdy = ($urandom % 3) != 0;
            j   = 2'($urandom % 4);
            br  = $urandom % 2 == 1;
            case ($urandom % 4)
                0: jt = 32'hFFFF_FFFC;
                1: jt = $urandom & 32'h0000_0FFF;
                default: jt = $urandom;
            endcase
            step(rn, g, rv, $urandom, rdy, j, br, jt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder/control block. Owns the PC and fetches one instruction at a time from instruction memory over a request/grant/response handshake.
- Presents the fetched word to decode and holds it until decode consumes it.
- On consumption, computes the next PC from decode's Jump/Branch outputs. No delay slot; non-pipelined, one outstanding request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  synchronous active-low reset.
imem_req  output  1  fetch request valid.
imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
imem_gnt  input  1  memory accepts request this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  32  fetched instruction word.
instruction  output  32  held instruction to decode.
instr_valid  output  1  instruction holds a fresh word.
instr_ready  input  1  decode consumes the instruction this cycle.
pc  output  32  address of the held or in-flight instruction.
pc_plus4  output  32  pc+4, combinational; decode uses it for the jal link value.
jump  input  2  from decode: 00 none, 01 jr, 10 j, 11 jal.
branch_taken  input  1  Branch AND condition met, resolved by the datapath.
jr_target  input  32  rs register value for jr.
addr_err  output  1  one-cycle pulse: jr target had bits [1:0] != 0.

Behaviour:
- Reset (reset_n=0 at a clock edge), whatever the current state:
  - state=REQ, pc=RESET_PC, instruction=0, instr_valid=0, addr_err=0.
  - imem_req=1 from the first cycle after reset deasserts.
- FSM, 3 states:
  - REQ: imem_req=1, imem_addr=pc. imem_gnt=1 → WAIT. Otherwise stay. imem_rvalid is ignored in REQ.
  - WAIT: imem_req=0. imem_rvalid=1 → capture imem_rdata into instruction, set instr_valid=1, go to VALID. Otherwise stay; no timeout.
  - VALID: instr_valid=1; instruction and pc are held stable.
    - instr_ready=1 → pc <= next_pc, instr_valid <= 0, go to REQ.
    - instr_ready=0 → stay.
    - imem_rvalid is ignored in VALID.
- Timing: the response must arrive no earlier than the cycle after grant. Minimum latency from grant to instr_valid is 2 cycles (gnt at edge N, rvalid during N+1, instr_valid from edge N+2).
- next_pc is combinational from the held instruction and is sampled only when VALID and instr_ready=1. Priority order:
  1. jump=01 (jr): {jr_target[31:2], 2'b00}. If jr_target[1:0] != 0, pulse addr_err for the cycle after consumption.
  2. jump=10 or 11 (j/jal): {pc_plus4[31:28], instruction[25:0], 2'b00}.
  3. branch_taken=1: pc_plus4 + ({{14{instruction[15]}}, instruction[15:0], 2'b00}). 32-bit wrap-around; no overflow flag.
  4. Otherwise: pc_plus4.
- Jump takes priority over branch_taken when both are asserted.
- pc_plus4 = pc + 4, modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal.
- Outputs other than pc_plus4 and imem_addr are registered. imem_req is derived from state only; no combinational path from imem_gnt.
- jump, branch_taken and jr_target are don't-care outside VALID with instr_ready=1.

Test Plan:
- Reset, then sequential fetch: RESET_PC=0; memory grants immediately and returns rvalid one cycle later with words 0x2008_0005, 0x0000_0000; instr_ready tied high → imem_addr sequence 0x0, 0x4, 0x8; instr_valid rises 2 cycles after each grant; instruction matches each word in order.
- Stall: hold instr_ready=0 for 5 cycles in VALID → instruction, pc and instr_valid stable; imem_req=0 throughout; stray imem_rvalid pulses ignored.
- j/jal: pc=0x0040_0010, instruction=0x0C00_0100, jump=11 → next imem_addr=0x0000_0400; pc_plus4=0x0040_0014 while VALID.
- jr with misaligned target: jump=01, jr_target=0x0000_1236 → imem_addr=0x0000_1234; addr_err high for exactly 1 cycle.
- Branch: pc=0x100, imm=0xFFFE, branch_taken=1 → next pc=0x0FC. Same instruction with branch_taken=0 → 0x104. jump=10 together with branch_taken=1 → jump target wins.
- Reset mid-operation: assert reset_n=0 in WAIT, then deliver imem_rvalid in the first post-reset cycle → response ignored; state REQ; imem_addr=RESET_PC; instr_valid=0.
